// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRA/SRL/ROR) with valid/ready handshake.
// Stage 1 applies the upper half of the shift amount; stage 2 applies the lower half.
module shift_pipe #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int LW = SW / 2;
  localparam int HW = SW - LW;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_SRL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // One mux layer per amount bit; zero bits in amt make a layer a pass-through.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] data,
                                              input logic [1:0]       mode,
                                              input logic [SW-1:0]    amt);
    logic [WIDTH-1:0] res;
    res = data;
    for (int i = 0; i < SW; i++) begin
      if (amt[i]) begin
        case (mode)
          MODE_SLL: res = res << (1 << i);
          MODE_SRA: res = $signed(res) >>> (1 << i);
          MODE_SRL: res = res >> (1 << i);
          MODE_ROR: res = (res >> (1 << i)) | (res << (WIDTH - (1 << i)));
          default:  res = res;
        endcase
      end
    end
    return res;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic [LW-1:0]    s1_amt_lo;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zero;

  logic             s2_load;
  logic             s1_load;
  logic [SW-1:0]    s1_amt_full;
  logic [SW-1:0]    s2_amt_full;
  logic [WIDTH-1:0] s1_shift;
  logic [WIDTH-1:0] s2_shift;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !flush && s1_load;

  assign s1_amt_full = {in_amt[SW-1:LW], {LW{1'b0}}};
  assign s2_amt_full = {{HW{1'b0}}, s1_amt_lo};
  assign s1_shift    = barrel(in_data, in_mode, s1_amt_full);
  assign s2_shift    = barrel(s1_data, s1_mode, s2_amt_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= '0;
      s1_amt_lo <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_zero   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_load) s2_valid <= s1_valid;
        if (s1_load) s1_valid <= in_valid;
      end
      // Data registers only move with a real operand, keeping a stalled output stable.
      if (s2_load && s1_valid) begin
        s2_data <= s2_shift;
        s2_zero <= (s2_shift == '0);
      end
      if (s1_load && in_valid) begin
        s1_data   <= s1_shift;
        s1_mode   <= in_mode;
        s1_amt_lo <= in_amt[LW-1:0];
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_zero;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=16): directed vector table, handshake
// corner sequences, and randomised traffic scored against a per-bit reference model.
module tb_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;

  int checks;
  int failures;
  int n_acc;

  typedef struct {
    logic [15:0] data;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] dout;
    logic        zero;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];

  logic        prev_stall;
  logic        prev_flush;
  logic [15:0] prev_data;
  logic        prev_zero;

  shift_pipe #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each result bit is picked directly from its source bit index.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] m, input int a);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      case (m)
        2'b00: r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'b01: r[i] = (i + a < 16) ? d[i+a] : d[15];
        2'b10: r[i] = (i + a < 16) ? d[i+a] : 1'b0;
        default: r[i] = d[(i+a) % 16];
      endcase
    end
    return r;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
        chk("stall_zero", out_zero, prev_zero);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_zero", out_zero, e.zero);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = ref_shift(in_data, in_mode, int'(in_amt));
        e.zero = (e.data == 16'h0000);
        exp_q.push_back(e);
        n_acc++;
      end
      if (flush) exp_q.delete();
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_data  = out_data;
      prev_zero  = out_zero;
    end
  end

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d, input logic [3:0] a);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
    in_amt   = a;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int start;

    vecs[0]  = '{2'b00, 16'h8001, 4'd1,  16'h0002, 1'b0};
    vecs[1]  = '{2'b01, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
    vecs[2]  = '{2'b10, 16'h8000, 4'd15, 16'h0001, 1'b0};
    vecs[3]  = '{2'b11, 16'h0001, 4'd1,  16'h8000, 1'b0};
    vecs[4]  = '{2'b00, 16'h8000, 4'd1,  16'h0000, 1'b1};
    vecs[5]  = '{2'b00, 16'h1234, 4'd0,  16'h1234, 1'b0};
    vecs[6]  = '{2'b01, 16'h8765, 4'd0,  16'h8765, 1'b0};
    vecs[7]  = '{2'b10, 16'hABCD, 4'd0,  16'hABCD, 1'b0};
    vecs[8]  = '{2'b11, 16'h0001, 4'd0,  16'h0001, 1'b0};
    vecs[9]  = '{2'b11, 16'h1234, 4'd4,  16'h4123, 1'b0};
    vecs[10] = '{2'b01, 16'h7FF0, 4'd4,  16'h07FF, 1'b0};
    vecs[11] = '{2'b10, 16'hF000, 4'd12, 16'h000F, 1'b0};
    vecs[12] = '{2'b00, 16'h00FF, 4'd8,  16'hFF00, 1'b0};
    vecs[13] = '{2'b01, 16'h9000, 4'd3,  16'hF200, 1'b0};
    vecs[14] = '{2'b11, 16'h8001, 4'd15, 16'h0003, 1'b0};
    vecs[15] = '{2'b10, 16'h0001, 4'd1,  16'h0000, 1'b1};

    checks = 0;
    failures = 0;
    n_acc = 0;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    prev_data = '0;
    prev_zero = 1'b0;
    rst_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 4'd0);

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_zero", out_zero, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed vectors with latency check
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(1'b1, vecs[i].mode, vecs[i].din, vecs[i].amt);
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_lat1_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("vec_lat2_valid", out_valid, 1'b1);
      chk("vec_data", out_data, vecs[i].dout);
      chk("vec_zero", out_zero, vecs[i].zero);
    end
    drain("vec_drain");

    // Backpressure: four operands, output stalled for three cycles
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 16'h0011, 4'd1);
    @(negedge clk); chk("bp_rdy_a", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 16'hF0F0, 4'd4);
    @(negedge clk); chk("bp_rdy_b", in_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 2'b11, 16'h00F1, 4'd4);
    @(negedge clk);
    chk("bp_full_c", in_ready, 1'b0);
    chk("bp_valid_c", out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_full_d", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); chk("bp_rdy_e", in_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 16'h8F00, 4'd8);
    @(negedge clk); chk("bp_rdy_f", in_ready, 1'b1);
    @(posedge clk); #1;
    drain("bp_drain");
    chk("bp_count", n_acc, 16 + 4);

    // Flush with two in flight plus a same-cycle operand
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0101, 4'd2);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 16'h0202, 4'd3);
    @(posedge clk); #1;
    flush = 1'b1;
    drive(1'b1, 2'b11, 16'h5555, 4'd5);
    @(negedge clk);
    chk("fl_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_result", out_valid, 1'b0);
    end
    chk("fl_count", n_acc, 22);

    // Reset mid-operation
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0F0F, 4'd1);
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 16'hF0F0, 4'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs_pre_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", out_valid, 1'b0);
    chk("rs_out_data", out_data, 16'h0000);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rs_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_no_stale", out_valid, 1'b0);
    end

    // Randomised traffic with occasional flush
    start = n_acc;
    cyc = 0;
    while ((n_acc - start) < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 199) == 0);
      cyc++;
    end
    @(posedge clk); #1;
    flush = 1'b0;
    chk("rand_ops_done", ((n_acc - start) >= 10000), 1'b1);
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
